// File: rtl/hold_limit_allocator_core_if.sv
// Bundle between the input ports and the allocator. request/on_off/flush go in,
// and grant/grant_dest come back.
interface hold_limit_allocator_core_if #(
  parameter int N    = 5,
  parameter int M    = 4,
  parameter int SIZE = 5
);
  // Contract: there is no valid/ready pairing. request[k][j][i] is a level that
  // stays high while input k VC j wants output i. A grant is valid only in the
  // cycle it is shown, and the requester drops or keeps its request on its own.
  logic [SIZE-1:0][M-1:0][N-1:0] request;
  logic [SIZE-1:0][M-1:0]        on_off;
  logic                          flush;
  logic [SIZE-1:0][M-1:0]        grant;
  logic [SIZE-1:0][M-1:0][N-1:0] grant_dest;

  modport master (output request, on_off, flush, input grant, grant_dest);
  modport slave  (input request, on_off, flush, output grant, grant_dest);
endinterface

// File: rtl/hold_limit_allocator_core.sv
// Per (output, VC) round-robin allocator with bounded grant-hold.
// Blocked requesters are masked before arbitration.
module hold_limit_allocator_core #(
  parameter int N        = 5,
  parameter int M        = 4,
  parameter int SIZE     = 5,
  parameter int MAX_HOLD = 4,
  parameter int OUT_REG  = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  hold_limit_allocator_core_if.slave bus
);
  localparam int PTR_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam bit LIMITED = (MAX_HOLD > 0);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [SIZE-1:0] ONE = SIZE'(1);

  logic [SIZE-1:0]  holder_q   [N][M];
  logic [SIZE-1:0]  holder_d   [N][M];
  logic [PTR_W-1:0] rr_q       [N][M];
  logic [PTR_W-1:0] rr_d       [N][M];
  logic [CNT_W-1:0] hold_cnt_q [N][M];
  logic [CNT_W-1:0] hold_cnt_d [N][M];
  logic [SIZE-1:0]  win        [N][M];

  logic [SIZE-1:0][M-1:0][N-1:0] dest_c;
  logic [SIZE-1:0][M-1:0]        grant_c;

  always_comb begin
    logic [SIZE-1:0] eff;
    logic [SIZE-1:0] others;
    logic [SIZE-1:0] scan;
    logic            at_limit;
    logic            keep;
    logic            found;
    int              w;
    int              idx;
    eff      = '0;
    others   = '0;
    scan     = '0;
    at_limit = 1'b0;
    keep     = 1'b0;
    found    = 1'b0;
    w        = 0;
    idx      = 0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < M; j++) begin
        for (int k = 0; k < SIZE; k++)
          eff[k] = bus.request[k][j][i] & ~bus.on_off[k][j];
        others   = eff & ~holder_q[i][j];
        at_limit = LIMITED && (hold_cnt_q[i][j] == HOLD_MAX);
        keep     = (|(eff & holder_q[i][j])) && (!at_limit || (others == '0));
        // An expiring holder is removed from the scan so any contender wins.
        scan     = at_limit ? others : eff;
        found    = 1'b0;
        w        = 0;
        for (int off = 0; off < SIZE; off++) begin
          idx = int'(rr_q[i][j]) + off;
          if (idx >= SIZE) idx = idx - SIZE;
          if (!found && scan[idx]) begin
            found = 1'b1;
            w     = idx;
          end
        end

        win[i][j]        = '0;
        holder_d[i][j]   = holder_q[i][j];
        rr_d[i][j]       = rr_q[i][j];
        hold_cnt_d[i][j] = hold_cnt_q[i][j];
        if (eff == '0) begin
          holder_d[i][j]   = '0;
          hold_cnt_d[i][j] = '0;
        end else if (keep) begin
          win[i][j] = holder_q[i][j];
          if (LIMITED && !at_limit) hold_cnt_d[i][j] = hold_cnt_q[i][j] + 1'b1;
        end else begin
          win[i][j]        = ONE << w;
          holder_d[i][j]   = ONE << w;
          rr_d[i][j]       = PTR_W'((w == SIZE - 1) ? 0 : w + 1);
          hold_cnt_d[i][j] = CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset || bus.flush) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < M; j++) begin
          holder_q[i][j]   <= '0;
          rr_q[i][j]       <= '0;
          hold_cnt_q[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < M; j++) begin
          holder_q[i][j]   <= holder_d[i][j];
          rr_q[i][j]       <= rr_d[i][j];
          hold_cnt_q[i][j] <= hold_cnt_d[i][j];
        end
      end
    end
  end

  // Outputs are forced low during reset and in a flush cycle.
  always_comb begin
    dest_c  = '0;
    grant_c = '0;
    if (reset && !bus.flush) begin
      for (int k = 0; k < SIZE; k++)
        for (int j = 0; j < M; j++)
          for (int i = 0; i < N; i++)
            dest_c[k][j][i] = win[i][j][k];
    end
    for (int k = 0; k < SIZE; k++)
      for (int j = 0; j < M; j++)
        grant_c[k][j] = |dest_c[k][j];
  end

  generate
    if (OUT_REG != 0) begin : g_reg
      logic [SIZE-1:0][M-1:0][N-1:0] dest_q;
      logic [SIZE-1:0][M-1:0]        grant_q;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          dest_q  <= '0;
          grant_q <= '0;
        end else begin
          dest_q  <= dest_c;
          grant_q <= grant_c;
        end
      end
      assign bus.grant_dest = dest_q;
      assign bus.grant      = grant_q;
    end else begin : g_comb
      assign bus.grant_dest = dest_c;
      assign bus.grant      = grant_c;
    end
  endgenerate
endmodule
